instr_fetch: RTL
================

// Module: instr_fetch
// PURPOSE
//  Fetch stage of the 8-bit core, directly upstream of the instruction memory: owns the PC and drives the IMEM read address.
//  Captures the returned instruction byte into a registered fetch slot. Hands it to decode over a valid/ready handshake.
//  Accepts PC redirects from execute (jumps) and flags out-of-range fetches.
// PARAMETERS
//  ADDR_W     8     PC / IMEM address width
//  INSTR_W    8     instruction width
//  IMEM_DEPTH 9     number of populated IMEM bytes; pc >= IMEM_DEPTH is a fault
//  RESET_PC   8'h00 PC value after reset
// PORTS
//  clk            in   1        rising-edge clock
//  rst_n          in   1        asynchronous active-low reset
//  imem_addr      out  ADDR_W   read address to IMEM (= pc, combinational)
//  imem_instr     in   INSTR_W  IMEM data, combinational same cycle
//  if_valid       out  1        fetch slot holds a live instruction
//  if_instr       out  INSTR_W  registered instruction
//  if_pc          out  ADDR_W   address if_instr was fetched from
//  if_pred_taken  out  1        slot is a JMP already followed by fetch
//  id_ready       in   1        decode accepts slot this cycle
//  redirect_valid in   1        execute redirect request
//  redirect_pc    in   ADDR_W   redirect target
//  fetch_fault    out  1        sticky: pc reached >= IMEM_DEPTH
// BEHAVIOUR
//  - Reset (async, rst_n=0): pc=RESET_PC; if_valid=0, if_instr=0, if_pc=0, if_pred_taken=0, fetch_fault=0.
//  - accept = !if_valid || id_ready. Transfer to decode = if_valid && id_ready.
//  - Fetch in cycle N when accept && !fetch_fault && pc<IMEM_DEPTH && !redirect_valid.
//    On the edge ending N: if_instr<=imem_instr, if_pc<=pc, if_valid<=1, pc<=next_pc. Latency is 1 cycle, address to if_valid.
//  - Stall (if_valid && !id_ready): pc and slot hold. imem_addr stays stable.
//  - Slot drains without refill (accept but no fetch): if_valid<=0.
//  - Redirect has top priority, even during a stall: pc<=redirect_pc, if_valid<=0, fetch_fault<=0. No fetch that cycle.
//  - Fault: accept && pc>=IMEM_DEPTH && !redirect_valid -> fetch_fault<=1 (sticky). pc holds, if_valid<=0.
//    Only a redirect or reset clears it.
//  - next_pc = pc+1 mod 2^ADDR_W (0xFF wraps to 0x00), unless predecode applies.
//  - Encoding: [7:6] opcode: 00 ADD, 01 LD, 10 ST, 11 JMP. JMP: [5:0] unsigned backward distance.
//    JMP target = pc - instr[5:0] mod 2^ADDR_W.
//  - Async reset mid-stall or mid-redirect discards all state immediately.
// CONFIGURATION
//  FETCH_JUMP_PREDECODE_EN defined: if imem_instr[7:6]==2'b11 at fetch, next_pc = JMP target and if_pred_taken<=1.
//    Execute must not re-redirect a slot with if_pred_taken=1. Any redirect it does issue still wins.
//  Undefined: next_pc always pc+1. if_pred_taken tied 0. Execute resolves every JMP via redirect.
// STRUCTURE
//  Package fetch_pkg: OP_ADD/OP_LD/OP_ST/OP_JMP 2-bit constants, field slice localparams (OPC_MSB/LSB, JOFF_MSB/LSB).
//    Also function jmp_target(pc, instr). Shared with decode and execute.
//  Sub-module fetch_pc_next: combinational next_pc and pred_taken from pc and imem_instr (macro-aware).
//  All sequential state lives in instr_fetch.
// TESTING
//  1 Reset, id_ready=1, IMEM holds 41,00,00,00,00,69,B1,79,C2 ->
//    if_instr sequence 41,00,00,00,00,69,B1,79,C2 with if_pc 0..8, one per cycle from cycle 1.
//  2 id_ready=0 for 3 cycles while if_pc=2 -> if_instr/if_pc/imem_addr hold (00/2/3). Resumes with if_pc=3 after release.
//  3 redirect_valid=1, redirect_pc=5 during a stall -> next cycle if_valid=0, imem_addr=5. Following cycle if_instr=69, if_pc=5.
//  4 Predecode on, C2 at pc 8 -> if_pred_taken=1, if_pc=8. Next fetch pc=6 (if_instr=B1).
//    Predecode off -> next pc=9, fetch_fault=1, if_valid=0.
//  5 With fetch_fault=1, redirect_pc=0 -> fault clears, if_instr=41 two cycles later.
//    RESET_PC=8'hFF with IMEM_DEPTH=256: pc wraps FF->00.
//  6 rst_n low mid-stall -> all outputs 0 asynchronously. After release imem_addr=RESET_PC, first if_valid one cycle later.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared encoding constants and helpers for the 8-bit core's fetch, decode and execute stages.
// Jump predecode in fetch is enabled by defining FETCH_JUMP_PREDECODE_EN.
package fetch_pkg;

    localparam int unsigned CORE_W = 8;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_LD  = 2'b01;
    localparam logic [1:0] OP_ST  = 2'b10;
    localparam logic [1:0] OP_JMP = 2'b11;

    localparam int unsigned OPC_MSB  = 7;
    localparam int unsigned OPC_LSB  = 6;
    localparam int unsigned JOFF_MSB = 5;
    localparam int unsigned JOFF_LSB = 0;

    typedef enum logic [1:0] {
        OpAdd = 2'b00,
        OpLd  = 2'b01,
        OpSt  = 2'b10,
        OpJmp = 2'b11
    } opcode_e;

    function automatic opcode_e get_opcode(input logic [CORE_W-1:0] instr);
        return opcode_e'(instr[OPC_MSB:OPC_LSB]);
    endfunction

    function automatic logic is_jmp(input logic [CORE_W-1:0] instr);
        return instr[OPC_MSB:OPC_LSB] == OP_JMP;
    endfunction

    // JMP offset is an unsigned backward distance; subtraction wraps mod 2^CORE_W.
    function automatic logic [CORE_W-1:0] jmp_target(input logic [CORE_W-1:0] pc,
                                                     input logic [CORE_W-1:0] instr);
        logic [CORE_W-1:0] off;
        off = {2'b00, instr[JOFF_MSB:JOFF_LSB]};
        return pc - off;
    endfunction

endpackage

// File: rtl/fetch_pc_next.sv
// Combinational next-PC for the fetch stage; follows JMPs at fetch time only when
// FETCH_JUMP_PREDECODE_EN is defined, otherwise always sequential.
module fetch_pc_next
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned INSTR_W = 8
) (
    input  logic [ADDR_W-1:0]  pc_i,
    input  logic [INSTR_W-1:0] instr_i,
    output logic [ADDR_W-1:0]  next_pc_o,
    output logic               pred_taken_o
);

    logic [ADDR_W-1:0] seq_pc;

    assign seq_pc = pc_i + ADDR_W'(1);

`ifdef FETCH_JUMP_PREDECODE_EN
    logic              jmp_hit;
    logic [ADDR_W-1:0] jmp_off;

    assign jmp_hit = instr_i[OPC_MSB:OPC_LSB] == OP_JMP;
    assign jmp_off = ADDR_W'(instr_i[JOFF_MSB:JOFF_LSB]);

    always_comb begin
        pred_taken_o = jmp_hit;
        next_pc_o    = jmp_hit ? (pc_i - jmp_off) : seq_pc;
    end
`else
    logic unused_instr;

    assign unused_instr = ^instr_i;
    assign next_pc_o    = seq_pc;
    assign pred_taken_o = 1'b0;
`endif

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, drives IMEM, holds one registered fetch slot for decode.
// FETCH_JUMP_PREDECODE_EN selects fetch-time JMP following (see fetch_pc_next).
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W     = 8,
    parameter int unsigned       INSTR_W    = 8,
    parameter int unsigned       IMEM_DEPTH = 9,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [ADDR_W-1:0]  imem_addr_o,
    input  logic [INSTR_W-1:0] imem_instr_i,
    output logic               if_valid_o,
    output logic [INSTR_W-1:0] if_instr_o,
    output logic [ADDR_W-1:0]  if_pc_o,
    output logic               if_pred_taken_o,
    input  logic               id_ready_i,
    input  logic               redirect_valid_i,
    input  logic [ADDR_W-1:0]  redirect_pc_i,
    output logic               fetch_fault_o
);

    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  slot_pc_q, slot_pc_d;
    logic               valid_q, valid_d;
    logic               pred_q, pred_d;
    logic               fault_q, fault_d;

    logic [ADDR_W-1:0]  next_pc;
    logic               pred_next;
    logic               accept;
    logic               in_range;
    logic               fetch_en;

    fetch_pc_next #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
    ) u_pc_next (
        .pc_i         (pc_q),
        .instr_i      (imem_instr_i),
        .next_pc_o    (next_pc),
        .pred_taken_o (pred_next)
    );

    assign accept   = !valid_q || id_ready_i;
    assign in_range = 32'(pc_q) < IMEM_DEPTH;
    assign fetch_en = accept && !fault_q && in_range && !redirect_valid_i;

    always_comb begin
        pc_d      = pc_q;
        instr_d   = instr_q;
        slot_pc_d = slot_pc_q;
        valid_d   = valid_q;
        pred_d    = pred_q;
        fault_d   = fault_q;
        // Redirect wins over everything, including a stalled slot.
        if (redirect_valid_i) begin
            pc_d    = redirect_pc_i;
            valid_d = 1'b0;
            pred_d  = 1'b0;
            fault_d = 1'b0;
        end else if (fetch_en) begin
            instr_d   = imem_instr_i;
            slot_pc_d = pc_q;
            valid_d   = 1'b1;
            pred_d    = pred_next;
            pc_d      = next_pc;
        end else if (accept) begin
            valid_d = 1'b0;
            pred_d  = 1'b0;
            if (!in_range) begin
                fault_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= RESET_PC;
            instr_q   <= '0;
            slot_pc_q <= '0;
            valid_q   <= 1'b0;
            pred_q    <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            slot_pc_q <= slot_pc_d;
            valid_q   <= valid_d;
            pred_q    <= pred_d;
            fault_q   <= fault_d;
        end
    end

    assign imem_addr_o     = pc_q;
    assign if_valid_o      = valid_q;
    assign if_instr_o      = instr_q;
    assign if_pc_o         = slot_pc_q;
    assign if_pred_taken_o = pred_q;
    assign fetch_fault_o   = fault_q;

    a_fault_empty_slot : assert property (@(posedge clk) disable iff (!rst_n)
        fetch_fault_o |-> !if_valid_o);

    a_pred_needs_slot : assert property (@(posedge clk) disable iff (!rst_n)
        if_pred_taken_o |-> if_valid_o);

endmodule
